vdp_port_ctrl: RTL and testbench

CPU-side controller for the TMS9918-style VDP in the MSX core. It decodes Z80 I/O accesses to ports 0x98 (data) and 0x99 (control/status), runs the two-byte control-word state machine, and holds VDP registers R0–R7, the 14-bit VRAM address pointer and the read-ahead latch. It also schedules the single VRAM port between CPU accesses and video refresh fetches, and generates the frame interrupt. It sits between the tv80n bus decode and the video block / VRAM.

---
 rtl/vdp_port_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_vdp_port_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller for a TMS9918-style VDP: I/O decode, control-word
// state machine, register file, VRAM pointer/read-ahead, VRAM port arbitration.
module vdp_port_ctrl #(
   parameter int unsigned STARVE = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_ena,
   input  logic        io_wr_n,
   input  logic        io_rd_n,
   input  logic [7:0]  port_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_dout_en,
   output logic        wait_n,
   input  logic        vid_req,
   input  logic [13:0] vid_addr,
   output logic        vid_grant,
   output logic [13:0] vram_addr,
   output logic        vram_we,
   output logic [7:0]  vram_wdata,
   input  logic [7:0]  vram_rdata,
   input  logic        vblank,
   output logic [63:0] regs,
   output logic        int_n
);

   localparam int unsigned SW = $clog2(STARVE + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_ACTIVE} state_t;
   typedef enum logic [2:0] {K_NONE, K_WR_DATA, K_WR_CTRL, K_RD_DATA, K_RD_CTRL} kind_t;

   state_t            state_q, state_d;
   kind_t             kind_q, kind_d, cur;
   logic              tog_q, tog_d;
   logic [7:0]        first_q, first_d;
   logic [7:0][7:0]   regs_q, regs_d;
   logic [13:0]       addr_q, addr_d, addr_cur;
   logic [7:0]        latch_q, latch_d;
   logic              flag_q, flag_d;
   logic              slot_vld_q, slot_vld_d;
   logic              slot_wr_q, slot_wr_d;
   logic [7:0]        slot_data_q, slot_data_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              rd_pend_q, rd_pend_d;

   logic              ok, accept, finish, clr;
   logic              op_vld, op_wr;
   logic              eff_vld, eff_wr, cpu_issue;
   logic [7:0]        eff_data;

   always_comb begin
      cur = K_NONE;
      if (!io_wr_n && port_addr == 8'h98)      cur = K_WR_DATA;
      else if (!io_wr_n && port_addr == 8'h99) cur = K_WR_CTRL;
      else if (!io_rd_n && port_addr == 8'h98) cur = K_RD_DATA;
      else if (!io_rd_n && port_addr == 8'h99) cur = K_RD_CTRL;
   end

   // Only accesses that need the pending slot (or a loaded latch) can stall.
   always_comb begin
      unique case (cur)
         K_WR_DATA: ok = !slot_vld_q;
         K_RD_DATA: ok = !slot_vld_q && !rd_pend_q;
         K_WR_CTRL: ok = !(tog_q && cpu_din[7:6] == 2'b00 && slot_vld_q);
         default:   ok = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      tog_d    = tog_q;
      first_d  = first_q;
      regs_d   = regs_q;
      addr_cur = addr_q;
      accept   = 1'b0;
      finish   = 1'b0;
      clr      = 1'b0;
      op_vld   = 1'b0;
      op_wr    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (clk_ena && cur != K_NONE) begin
               kind_d = cur;
               if (ok) begin
                  accept  = 1'b1;
                  state_d = ST_ACTIVE;
               end else begin
                  state_d = ST_STALL;
               end
            end
         end
         ST_STALL: begin
            if (clk_ena) begin
               if (cur != kind_q) begin
                  state_d = ST_IDLE;
               end else if (ok) begin
                  accept  = 1'b1;
                  state_d = ST_ACTIVE;
               end
            end
         end
         default: begin
            if (clk_ena && cur != kind_q) begin
               finish  = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase

      if (accept) begin
         unique case (cur)
            K_WR_DATA: begin
               op_vld = 1'b1;
               op_wr  = 1'b1;
               tog_d  = 1'b0;
            end
            K_WR_CTRL: begin
               if (!tog_q) begin
                  first_d = cpu_din;
                  tog_d   = 1'b1;
               end else begin
                  tog_d = 1'b0;
                  if (cpu_din[7]) begin
                     if (cpu_din[5:3] == 3'd0) regs_d[cpu_din[2:0]] = first_q;
                  end else begin
                     addr_cur = {cpu_din[5:0], first_q};
                     op_vld   = !cpu_din[6];
                  end
               end
            end
            default: ;
         endcase
      end

      if (finish) begin
         unique case (kind_q)
            K_RD_DATA: begin
               op_vld = 1'b1;
               tog_d  = 1'b0;
            end
            K_RD_CTRL: begin
               clr   = 1'b1;
               tog_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      flag_d = flag_q;
      if (vblank)   flag_d = 1'b1;
      else if (clr) flag_d = 1'b0;
   end

   // A freshly accepted op can issue in its acceptance cycle, so the scheduler
   // looks at the slot contents or, when empty, the incoming op.
   always_comb begin
      eff_vld   = slot_vld_q | op_vld;
      eff_wr    = slot_vld_q ? slot_wr_q : op_wr;
      eff_data  = slot_vld_q ? slot_data_q : cpu_din;
      cpu_issue = eff_vld && (!vid_req || starve_q == SW'(STARVE));

      slot_vld_d  = eff_vld;
      slot_wr_d   = eff_wr;
      slot_data_d = eff_data;
      starve_d    = eff_vld ? starve_q + SW'(1) : '0;
      addr_d      = addr_cur;
      rd_pend_d   = 1'b0;
      latch_d     = rd_pend_q ? vram_rdata : latch_q;

      if (cpu_issue) begin
         slot_vld_d = 1'b0;
         starve_d   = '0;
         addr_d     = addr_cur + 14'd1;
         rd_pend_d  = !eff_wr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         kind_q      <= K_NONE;
         tog_q       <= 1'b0;
         first_q     <= '0;
         regs_q      <= '0;
         addr_q      <= '0;
         latch_q     <= '0;
         flag_q      <= 1'b0;
         slot_vld_q  <= 1'b0;
         slot_wr_q   <= 1'b0;
         slot_data_q <= '0;
         starve_q    <= '0;
         rd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         tog_q       <= tog_d;
         first_q     <= first_d;
         regs_q      <= regs_d;
         addr_q      <= addr_d;
         latch_q     <= latch_d;
         flag_q      <= flag_d;
         slot_vld_q  <= slot_vld_d;
         slot_wr_q   <= slot_wr_d;
         slot_data_q <= slot_data_d;
         starve_q    <= starve_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

   always_comb begin
      vram_addr   = cpu_issue ? addr_cur : vid_addr;
      vram_we     = cpu_issue && eff_wr;
      vram_wdata  = eff_data;
      vid_grant   = vid_req && !cpu_issue;
      wait_n      = !(state_q == ST_STALL ||
                      (state_q == ST_IDLE && clk_ena && cur != K_NONE && !ok));
      cpu_dout_en = (state_q != ST_IDLE) && (kind_q == K_RD_DATA || kind_q == K_RD_CTRL);
      cpu_dout    = (kind_q == K_RD_CTRL) ? {flag_q, 7'b0} : latch_q;
      regs        = regs_q;
      int_n       = !(flag_q && regs_q[1][5]);
   end

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Directed self-checking bench for vdp_port_ctrl with a registered-read VRAM model.
module tb_vdp_port_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk_ena = 1'b1;
   logic        ena_toggle = 1'b0;
   logic        io_wr_n, io_rd_n;
   logic [7:0]  port_addr, cpu_din, cpu_dout;
   logic        cpu_dout_en, wait_n;
   logic        vid_req;
   logic [13:0] vid_addr;
   logic        vid_grant;
   logic [13:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata, vram_rdata;
   logic        vblank;
   logic [63:0] regs;
   logic        int_n;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mem [16384];
   logic        pre_we = 1'b0;
   logic [13:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;
   int          wr_cnt = 0;
   logic [13:0] last_wa = '0;
   logic [7:0]  last_wd = '0;

   vdp_port_ctrl #(.STARVE(8)) dut (
      .clk(clk), .reset_n(reset_n), .clk_ena(clk_ena),
      .io_wr_n(io_wr_n), .io_rd_n(io_rd_n), .port_addr(port_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_dout_en(cpu_dout_en),
      .wait_n(wait_n), .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_grant(vid_grant), .vram_addr(vram_addr), .vram_we(vram_we),
      .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vblank(vblank),
      .regs(regs), .int_n(int_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) clk_ena <= ena_toggle ? ~clk_ena : 1'b1;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (vram_we) begin
         mem[vram_addr] <= vram_wdata;
         wr_cnt         <= wr_cnt + 1;
         last_wa        <= vram_addr;
         last_wd        <= vram_wdata;
      end
      vram_rdata <= mem[vram_addr];
   end

   task automatic preload(input logic [13:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic io_wr(input logic [7:0] p, input logic [7:0] d);
      int n;
      @(negedge clk);
      port_addr = p; cpu_din = d; io_wr_n = 1'b0;
      repeat (3) @(negedge clk);
      n = 0;
      while (!wait_n && n < 200) begin @(negedge clk); n++; end
      if (!wait_n) begin
         n_cmp++; n_bad++;
         $display("FAIL io_wr_wait_timeout: wait_n=%b required 1", wait_n);
      end
      repeat (2) @(negedge clk);
      io_wr_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic io_rd(input logic [7:0] p, output logic [7:0] d, output logic en);
      int n;
      @(negedge clk);
      port_addr = p; io_rd_n = 1'b0;
      repeat (3) @(negedge clk);
      n = 0;
      while (!wait_n && n < 200) begin @(negedge clk); n++; end
      if (!wait_n) begin
         n_cmp++; n_bad++;
         $display("FAIL io_rd_wait_timeout: wait_n=%b required 1", wait_n);
      end
      repeat (2) @(negedge clk);
      d = cpu_dout; en = cpu_dout_en;
      io_rd_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; io_wr_n = 1'b1; io_rd_n = 1'b1; port_addr = '0; cpu_din = '0;
      vid_req = 1'b0; vid_addr = '0; vblank = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (wait_n !== 1'b1)      begin n_bad++; $display("FAIL rst_wait_n: got %b exp 1", wait_n); end
      n_cmp++; if (int_n !== 1'b1)       begin n_bad++; $display("FAIL rst_int_n: got %b exp 1", int_n); end
      n_cmp++; if (vram_we !== 1'b0)     begin n_bad++; $display("FAIL rst_vram_we: got %b exp 0", vram_we); end
      n_cmp++; if (vid_grant !== 1'b0)   begin n_bad++; $display("FAIL rst_vid_grant: got %b exp 0", vid_grant); end
      n_cmp++; if (cpu_dout_en !== 1'b0) begin n_bad++; $display("FAIL rst_dout_en: got %b exp 0", cpu_dout_en); end
      n_cmp++; if (regs !== 64'h0)       begin n_bad++; $display("FAIL rst_regs: got %h exp 0", regs); end
      reset_n = 1'b1;
      @(negedge clk);
      vid_req = 1'b1; vid_addr = 14'h1555;
      #1;
      n_cmp++; if (vid_grant !== 1'b1)        begin n_bad++; $display("FAIL idle_grant: got %b exp 1", vid_grant); end
      n_cmp++; if (vram_addr !== 14'h1555)    begin n_bad++; $display("FAIL idle_vaddr: got %h exp 1555", vram_addr); end
      @(negedge clk);
      vid_req = 1'b0;
   endtask

   task automatic test_reg_write;
      io_wr(8'h99, 8'hE0);
      io_wr(8'h99, 8'h81);
      n_cmp++; if (regs !== 64'h0000_0000_0000_E000) begin n_bad++; $display("FAIL reg_r1: got %h exp 000000000000e000", regs); end
      io_wr(8'h99, 8'h55);
      io_wr(8'h99, 8'h88);
      n_cmp++; if (regs !== 64'h0000_0000_0000_E000) begin n_bad++; $display("FAIL reg_ignored: got %h exp 000000000000e000", regs); end
      io_wr(8'h98, 8'h5A);
      n_cmp++; if (last_wa !== 14'h0000 || mem[0] !== 8'h5A) begin n_bad++; $display("FAIL reg_addr_kept: got %h/%h exp 0000/5a", last_wa, mem[0]); end
   endtask

   task automatic test_addr_write;
      io_wr(8'h99, 8'hFF);
      io_wr(8'h99, 8'h7F);
      io_wr(8'h98, 8'hAA);
      io_wr(8'h98, 8'hBB);
      n_cmp++; if (mem[16'h3FFF] !== 8'hAA) begin n_bad++; $display("FAIL wr_3fff: got %h exp aa", mem[16'h3FFF]); end
      n_cmp++; if (mem[0] !== 8'hBB)        begin n_bad++; $display("FAIL wr_wrap: got %h exp bb", mem[0]); end
      io_wr(8'h98, 8'hCC);
      n_cmp++; if (last_wa !== 14'h0001 || last_wd !== 8'hCC) begin n_bad++; $display("FAIL wr_next_addr: got %h/%h exp 0001/cc", last_wa, last_wd); end
   endtask

   task automatic test_read_ahead;
      logic [7:0] d; logic en;
      preload(14'h0100, 8'h12);
      preload(14'h0101, 8'h34);
      preload(14'h0102, 8'h56);
      io_wr(8'h99, 8'h00);
      io_wr(8'h99, 8'h01);
      io_rd(8'h98, d, en);
      n_cmp++; if (d !== 8'h12) begin n_bad++; $display("FAIL ra_first: got %h exp 12", d); end
      n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL ra_dout_en: got %b exp 1", en); end
      io_rd(8'h98, d, en);
      n_cmp++; if (d !== 8'h34) begin n_bad++; $display("FAIL ra_second: got %h exp 34", d); end
      io_rd(8'h98, d, en);
      n_cmp++; if (d !== 8'h56) begin n_bad++; $display("FAIL ra_third: got %h exp 56", d); end
      n_cmp++; if (cpu_dout_en !== 1'b0) begin n_bad++; $display("FAIL ra_dout_en_idle: got %b exp 0", cpu_dout_en); end
   endtask

   task automatic test_arbitration;
      int issue_t;
      io_wr(8'h99, 8'h00);
      io_wr(8'h99, 8'h40);
      vid_addr = 14'h2222;
      issue_t = -1;
      for (int t = 0; t < 26; t++) begin
         @(negedge clk);
         if (t == 0)  begin vid_req = 1'b1; port_addr = 8'h98; cpu_din = 8'h11; io_wr_n = 1'b0; end
         if (t == 1)  io_wr_n = 1'b1;
         if (t == 2)  begin cpu_din = 8'h22; io_wr_n = 1'b0; end
         if (t == 12) io_wr_n = 1'b1;
         #1;
         if (t <= 17) begin
            n_cmp++; if (vid_grant !== (t != 8 && t != 17)) begin n_bad++; $display("FAIL arb_grant_t%0d: got %b exp %b", t, vid_grant, (t != 8 && t != 17)); end
            n_cmp++; if (vram_we !== (t == 8 || t == 17))   begin n_bad++; $display("FAIL arb_we_t%0d: got %b exp %b", t, vram_we, (t == 8 || t == 17)); end
         end
         if (t >= 2 && t <= 10) begin
            n_cmp++; if (wait_n !== (t == 10)) begin n_bad++; $display("FAIL arb_wait_t%0d: got %b exp %b", t, wait_n, (t == 10)); end
         end
         if (t == 8) begin
            n_cmp++; if (vram_addr !== 14'h0000 || vram_wdata !== 8'h11) begin n_bad++; $display("FAIL arb_first_op: got %h/%h exp 0000/11", vram_addr, vram_wdata); end
         end
         if (t == 17) begin
            n_cmp++; if (vram_addr !== 14'h0001 || vram_wdata !== 8'h22) begin n_bad++; $display("FAIL arb_second_op: got %h/%h exp 0001/22", vram_addr, vram_wdata); end
         end
         if (t > 17 && vram_we && issue_t < 0) issue_t = t;
      end
      n_cmp++; if (issue_t != -1) begin n_bad++; $display("FAIL arb_extra_write: got write at t%0d exp none", issue_t); end
      vid_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_interrupt;
      logic [7:0] d; logic en;
      n_cmp++; if (int_n !== 1'b1) begin n_bad++; $display("FAIL irq_idle: got %b exp 1", int_n); end
      @(negedge clk); vblank = 1'b1;
      @(negedge clk); vblank = 1'b0;
      #1;
      n_cmp++; if (int_n !== 1'b0) begin n_bad++; $display("FAIL irq_set: got %b exp 0", int_n); end
      io_rd(8'h99, d, en);
      n_cmp++; if (d !== 8'h80) begin n_bad++; $display("FAIL irq_status: got %h exp 80", d); end
      n_cmp++; if (int_n !== 1'b1) begin n_bad++; $display("FAIL irq_cleared: got %b exp 1", int_n); end
      @(negedge clk); vblank = 1'b1;
      @(negedge clk); vblank = 1'b0;
      port_addr = 8'h99; io_rd_n = 1'b0;
      repeat (3) @(negedge clk);
      io_rd_n = 1'b1; vblank = 1'b1;
      @(negedge clk); vblank = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (int_n !== 1'b0) begin n_bad++; $display("FAIL irq_coincident: got %b exp 0", int_n); end
   endtask

   task automatic test_toggle;
      logic [7:0] d; logic en;
      ena_toggle = 1'b1;
      io_wr(8'h99, 8'h34);
      io_rd(8'h99, d, en);
      n_cmp++; if (d !== 8'h80) begin n_bad++; $display("FAIL tog_status: got %h exp 80", d); end
      io_wr(8'h99, 8'h12);
      io_wr(8'h99, 8'h40);
      io_wr(8'h98, 8'h9C);
      n_cmp++; if (last_wa !== 14'h0012 || mem[16'h0012] !== 8'h9C) begin n_bad++; $display("FAIL tog_addr: got %h/%h exp 0012/9c", last_wa, mem[16'h0012]); end
      ena_toggle = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_midop;
      int cnt0;
      @(negedge clk);
      vid_req = 1'b1; port_addr = 8'h98; cpu_din = 8'hEE; io_wr_n = 1'b0;
      repeat (3) @(negedge clk);
      cnt0 = wr_cnt;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      io_wr_n = 1'b1;
      @(negedge clk);
      reset_n = 1'b1; vid_req = 1'b0;
      repeat (12) @(negedge clk);
      n_cmp++; if (wr_cnt != cnt0)       begin n_bad++; $display("FAIL midrst_no_write: got %0d exp %0d", wr_cnt, cnt0); end
      n_cmp++; if (regs !== 64'h0)       begin n_bad++; $display("FAIL midrst_regs: got %h exp 0", regs); end
      n_cmp++; if (int_n !== 1'b1)       begin n_bad++; $display("FAIL midrst_int_n: got %b exp 1", int_n); end
      n_cmp++; if (wait_n !== 1'b1)      begin n_bad++; $display("FAIL midrst_wait_n: got %b exp 1", wait_n); end
      io_wr(8'h98, 8'h3C);
      n_cmp++; if (last_wa !== 14'h0000 || last_wd !== 8'h3C) begin n_bad++; $display("FAIL midrst_addr: got %h/%h exp 0000/3c", last_wa, last_wd); end
   endtask

   initial begin
      test_reset;
      test_reg_write;
      test_addr_write;
      test_read_ahead;
      test_arbitration;
      test_interrupt;
      test_toggle;
      test_reset_midop;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
